nn_layer_ctrl: RTL and testbench

- Sequencer for the 8-lane neural-network MAC datapath: one shared input x and eight weights w0..w7 per cycle, accumulators cleared by clr, sums on z0..z7.
- For one layer pass it pulses clr, streams n_in input/weight words from synchronous-read memories into the datapath, and waits for datapath latency.
- It then captures the eight sums and holds them behind a valid/ready handshake.
- Sits between the AXI-side command registers/BRAMs and the datapath.

---
 rtl/nn_layer_ctrl_if.sv | 34 +++
 rtl/nn_layer_ctrl.sv | 108 ++++++++++
 tb/tb_nn_layer_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_ctrl_if.sv
// Signal bundle between nn_layer_ctrl (slave) and its command, memory, datapath and result side (master).
interface nn_layer_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int NW = 8
);
  logic              start;
  logic [AW-1:0]     n_in;
  logic [AW-1:0]     x_base;
  logic [AW-1:0]     w_base;
  logic              busy;
  logic              done;
  logic [AW-1:0]     x_addr;
  logic [DW-1:0]     x_rdata;
  logic [AW-1:0]     w_addr;
  logic [NW*DW-1:0]  w_rdata;
  logic              dp_clr;
  logic [DW-1:0]     dp_x;
  logic [NW*DW-1:0]  dp_w;
  logic [NW*DW-1:0]  dp_z;
  logic [NW*DW-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;

  modport slave (
    input  start, n_in, x_base, w_base, x_rdata, w_rdata, dp_z, res_ready,
    output busy, done, x_addr, w_addr, dp_clr, dp_x, dp_w, res_data, res_valid
  );

  modport master (
    output start, n_in, x_base, w_base, x_rdata, w_rdata, dp_z, res_ready,
    input  busy, done, x_addr, w_addr, dp_clr, dp_x, dp_w, res_data, res_valid
  );
endinterface

// File: rtl/nn_layer_ctrl.sv
// Layer-pass sequencer for the 8-lane MAC datapath: clear, stream n_in terms, wait, capture, hand off.
// Optional macro NN_LAYER_CTRL_RELU_EN applies ReLU to every lane at capture.
module nn_layer_ctrl #(
  parameter int DW     = 16,
  parameter int AW     = 8,
  parameter int DP_LAT = 2,
  parameter int NW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  nn_layer_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CLR, FEED, WAIT, HOLD, DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    n_q;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    x_addr_q;
  logic [AW-1:0]    w_addr_q;
  logic [NW*DW-1:0] res_q;
  logic [NW*DW-1:0] z_cap;
  logic [AW:0]      next_idx;
  logic             accept;
  logic             advance;
  logic             last_feed;
  logic             wait_end;

  assign accept    = (state == IDLE) && bus.start;
  assign last_feed = (cnt == n_q - AW'(1));
  assign wait_end  = (cnt == AW'(DP_LAT - 1));
  assign next_idx  = {1'b0, cnt} + (AW+1)'(2);

  // Prefetch the next index one cycle ahead of its feed cycle; hold once the last one is out.
  assign advance = ((state == CLR) && (n_q > AW'(1))) ||
                   ((state == FEED) && (next_idx < {1'b0, n_q}));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.dp_clr    = (state == CLR);
    bus.res_valid = (state == HOLD);
    bus.dp_x      = '0;
    bus.dp_w      = '0;
    case (state)
      IDLE: if (bus.start) state_nxt = CLR;
      CLR:  state_nxt = (n_q == '0) ? WAIT : FEED;
      FEED: begin
        bus.dp_x = bus.x_rdata;
        bus.dp_w = bus.w_rdata;
        if (last_feed) state_nxt = WAIT;
      end
      WAIT: if (wait_end) state_nxt = HOLD;
      HOLD: if (bus.res_ready) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    z_cap = bus.dp_z;
`ifdef NN_LAYER_CTRL_RELU_EN
    for (int i = 0; i < NW; i++)
      if (bus.dp_z[i*DW + DW-1]) z_cap[i*DW +: DW] = '0;
`endif
  end

  // cnt counts feed terms in FEED and latency cycles in WAIT; it is zero on entry to each.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      cnt      <= '0;
      x_addr_q <= '0;
      w_addr_q <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        n_q      <= bus.n_in;
        x_addr_q <= bus.x_base;
        w_addr_q <= bus.w_base;
        cnt      <= '0;
      end
      if (advance) begin
        x_addr_q <= x_addr_q + AW'(1);
        w_addr_q <= w_addr_q + AW'(1);
      end
      case (state)
        FEED: cnt <= last_feed ? '0 : cnt + AW'(1);
        WAIT: begin
          cnt <= wait_end ? '0 : cnt + AW'(1);
          if (wait_end) res_q <= z_cap;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_addr   = x_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.res_data = res_q;

endmodule

// File: tb/tb_nn_layer_ctrl.sv
// Self-checking bench for nn_layer_ctrl: memory and MAC datapath models plus a result scoreboard.
module tb_nn_layer_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NW = 8;
  localparam int DP_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [DW-1:0]    xmem [256];
  logic [NW*DW-1:0] wmem [256];
  longint           acc  [NW];
  logic [NW*DW-1:0] z_q;
  logic [NW*DW-1:0] exp_q [$];

  nn_layer_ctrl_if #(.DW(DW), .AW(AW), .NW(NW)) bus ();

  nn_layer_ctrl #(.DW(DW), .AW(AW), .DP_LAT(DP_LAT), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with one cycle of read latency.
  always @(posedge clk) begin
    bus.x_rdata <= xmem[bus.x_addr];
    bus.w_rdata <= wmem[bus.w_addr];
  end

  // Free-running datapath: accumulator stage then output stage, so z lags the last term by two cycles.
  always @(posedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (bus.dp_clr) acc[i] <= 0;
      else acc[i] <= acc[i] + longint'($signed(bus.dp_x)) * longint'($signed(bus.dp_w[i*DW +: DW]));
      z_q[i*DW +: DW] <= DW'(acc[i] >>> 10);
    end
  end
  assign bus.dp_z = z_q;

  function automatic logic [NW*DW-1:0] ref_result(input logic [AW-1:0] xb, input logic [AW-1:0] wb, input int n);
    logic [NW*DW-1:0]   r;
    longint             s;
    logic [AW-1:0]      xa;
    logic [AW-1:0]      wa;
    logic signed [DW-1:0] lane;
    r = '0;
    for (int i = 0; i < NW; i++) begin
      s = 0;
      for (int k = 0; k < n; k++) begin
        xa = xb + AW'(k);
        wa = wb + AW'(k);
        s += longint'($signed(xmem[xa])) * longint'($signed(wmem[wa][i*DW +: DW]));
      end
      lane = DW'(s >>> 10);
`ifdef NN_LAYER_CTRL_RELU_EN
      if (lane < 0) lane = '0;
`endif
      r[i*DW +: DW] = lane;
    end
    return r;
  endfunction

  // Scoreboard: every completed handshake pops one expected result.
  always begin
    logic [NW*DW-1:0] e;
    @(negedge clk);
    #1;
    if (rst === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sb_unexpected got=%h with empty queue", bus.res_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.res_data !== e) begin
          n_fail++;
          $display("[TB] FAIL sb_res_data got=%h exp=%h", bus.res_data, e);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.n_in = 8'd5;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.done, bus.dp_clr, bus.res_valid} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctl got=%b exp=0000", {bus.busy, bus.done, bus.dp_clr, bus.res_valid});
    end
    n_tests++;
    if (bus.dp_x !== '0 || bus.dp_w !== '0 || bus.res_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data dp_x=%h dp_w=%h res=%h exp=0", bus.dp_x, bus.dp_w, bus.res_data);
    end
    n_tests++;
    if (bus.x_addr !== '0 || bus.w_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_addr x=%h w=%h exp=0", bus.x_addr, bus.w_addr);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b0 || bus.dp_clr !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_start_ignored busy=%b clr=%b exp=0", bus.busy, bus.dp_clr);
      end
    end
  endtask

  task automatic test_basic();
    int xs [6];
    int ws [6];
    xs = '{512, 410, 205, 410, 0, 717};
    ws = '{512, 717, 512, 1024, 205, 102};
    for (int k = 0; k < 6; k++) begin
      xmem[k] = DW'(xs[k]);
      wmem[k][DW-1:0] = DW'(ws[k]);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.n_in = 8'd6; bus.x_base = 8'd0; bus.w_base = 8'd0; bus.start = 1'b1;
    exp_q.push_back(ref_result(8'd0, 8'd0, 6));
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      n_tests++;
      if (bus.dp_clr !== (c == 1)) begin
        n_fail++; $display("[TB] FAIL basic_clr c=%0d got=%b exp=%b", c, bus.dp_clr, (c == 1));
      end
      n_tests++;
      if (bus.dp_x !== ((c >= 2 && c <= 7) ? xmem[c-2] : 16'd0) ||
          bus.dp_w[DW-1:0] !== ((c >= 2 && c <= 7) ? wmem[c-2][DW-1:0] : 16'd0)) begin
        n_fail++; $display("[TB] FAIL basic_feed c=%0d got x=%0d w0=%0d", c, bus.dp_x, bus.dp_w[DW-1:0]);
      end
      n_tests++;
      if (bus.res_valid !== (c == 10)) begin
        n_fail++; $display("[TB] FAIL basic_valid c=%0d got=%b exp=%b", c, bus.res_valid, (c == 10));
      end
      n_tests++;
      if (bus.done !== (c == 11)) begin
        n_fail++; $display("[TB] FAIL basic_done c=%0d got=%b exp=%b", c, bus.done, (c == 11));
      end
      n_tests++;
      if (bus.busy !== (c <= 11)) begin
        n_fail++; $display("[TB] FAIL basic_busy c=%0d got=%b exp=%b", c, bus.busy, (c <= 11));
      end
      if (c == 10) begin
        n_tests++;
        if (bus.res_data[DW-1:0] !== 16'd1127) begin
          n_fail++; $display("[TB] FAIL basic_lane0 got=%0d exp=1127", bus.res_data[DW-1:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NW*DW-1:0] held;
    bit seen;
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.n_in = 8'd3; bus.x_base = 8'd20; bus.w_base = 8'd40; bus.start = 1'b1;
    exp_q.push_back(ref_result(8'd20, 8'd40, 3));
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.res_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("[TB] FAIL bp_valid_timeout got=0 exp=1"); end
    held = bus.res_data;
    for (int h = 0; h < 20; h++) begin
      @(negedge clk);
      n_tests++;
      if (bus.res_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid h=%0d got=%b exp=1", h, bus.res_valid); end
      n_tests++;
      if (bus.res_data !== held) begin n_fail++; $display("[TB] FAIL bp_data h=%0d got=%h exp=%h", h, bus.res_data, held); end
      n_tests++;
      if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_done h=%0d got=%b exp=0", h, bus.done); end
      if (h == 5) begin bus.n_in = 8'd1; bus.x_base = 8'd7; bus.start = 1'b1; end
      if (h == 6) bus.start = 1'b0;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_after_ready done=%b valid=%b exp=1,0", bus.done, bus.res_valid);
    end
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_idle got=%b exp=0", bus.busy); end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_zero_wrap();
    logic [AW-1:0] ex [4];
    ex = '{8'd254, 8'd255, 8'd0, 8'd1};
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.n_in = 8'd0; bus.x_base = 8'd30; bus.w_base = 8'd30; bus.start = 1'b1;
    exp_q.push_back('0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      n_tests++;
      if (bus.res_valid !== (c == DP_LAT + 2)) begin
        n_fail++; $display("[TB] FAIL zero_valid c=%0d got=%b exp=%b", c, bus.res_valid, (c == DP_LAT + 2));
      end
      n_tests++;
      if (bus.dp_x !== '0) begin n_fail++; $display("[TB] FAIL zero_dp_x c=%0d got=%h exp=0", c, bus.dp_x); end
    end
    @(negedge clk);
    bus.n_in = 8'd4; bus.x_base = 8'd254; bus.w_base = 8'd253; bus.start = 1'b1;
    exp_q.push_back(ref_result(8'd254, 8'd253, 4));
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c <= 4) begin
        n_tests++;
        if (bus.x_addr !== ex[c-1] || bus.w_addr !== 8'(253 + c - 1)) begin
          n_fail++; $display("[TB] FAIL wrap_addr c=%0d got x=%0d w=%0d exp x=%0d", c, bus.x_addr, bus.w_addr, ex[c-1]);
        end
      end
      n_tests++;
      if (bus.res_valid !== (c == 8)) begin
        n_fail++; $display("[TB] FAIL wrap_valid c=%0d got=%b exp=%b", c, bus.res_valid, (c == 8));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.n_in = 8'd6; bus.x_base = 8'd0; bus.w_base = 8'd0; bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done, bus.res_valid, bus.dp_clr} !== 4'b0000 || bus.dp_x !== '0 || bus.dp_w !== '0) begin
      n_fail++;
      $display("[TB] FAIL midrst_idle busy=%b done=%b valid=%b x=%h w=%h exp all 0",
               bus.busy, bus.done, bus.res_valid, bus.dp_x, bus.dp_w);
    end
    repeat (15) begin
      @(negedge clk);
      n_tests++;
      if (bus.res_valid !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++; $display("[TB] FAIL midrst_quiet valid=%b done=%b exp=0,0", bus.res_valid, bus.done);
      end
    end
    bus.n_in = 8'd2; bus.x_base = 8'd60; bus.w_base = 8'd70; bus.start = 1'b1;
    exp_q.push_back(ref_result(8'd60, 8'd70, 2));
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("[TB] FAIL midrst_fresh_done got=0 exp=1"); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL midrst_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_relu();
    bit seen;
    for (int k = 100; k < 102; k++) begin
      xmem[k] = 16'd1024;
      wmem[k][DW-1:0] = 16'hFE00;
      for (int i = 1; i < NW; i++) wmem[k][i*DW +: DW] = 16'd256;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.n_in = 8'd2; bus.x_base = 8'd100; bus.w_base = 8'd100; bus.start = 1'b1;
    exp_q.push_back(ref_result(8'd100, 8'd100, 2));
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.res_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("[TB] FAIL relu_valid_timeout got=0 exp=1"); end
    n_tests++;
`ifdef NN_LAYER_CTRL_RELU_EN
    if (bus.res_data[DW-1:0] !== 16'd0) begin
      n_fail++; $display("[TB] FAIL relu_lane0 got=%0d exp=0", $signed(bus.res_data[DW-1:0]));
    end
`else
    if (bus.res_data[DW-1:0] !== 16'hFC00) begin
      n_fail++; $display("[TB] FAIL relu_lane0 got=%0d exp=-1024", $signed(bus.res_data[DW-1:0]));
    end
`endif
    n_tests++;
    if (bus.res_data[2*DW-1:DW] !== 16'd512) begin
      n_fail++; $display("[TB] FAIL relu_lane1 got=%0d exp=512", bus.res_data[2*DW-1:DW]);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.n_in = '0;
    bus.x_base = '0;
    bus.w_base = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      xmem[i] = DW'($urandom_range(0, 2047)) - 16'd1024;
      for (int l = 0; l < NW; l++) wmem[i][l*DW +: DW] = DW'($urandom_range(0, 2047)) - 16'd1024;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_wrap();
    test_reset_mid();
    test_relu();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL final_sb_left got=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
